// File: rtl/burst_mem_types.sv
// Shared widths and FSM state encoding for the burst memory responder.
package burst_mem_types;
  localparam int unsigned BEATS      = 4;
  localparam int unsigned BEAT_W     = 64;
  localparam int unsigned LINE_W     = 256;
  localparam int unsigned OFFSET_W   = 5;
  localparam int unsigned BEAT_IDX_W = $clog2(BEATS);

  typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} bm_state_t;
endpackage

// File: rtl/burst_mem_array.sv
// Line storage kept as DEPTH_LINES*BEATS 64-bit words so it maps onto a single block RAM.
module burst_mem_array
  import burst_mem_types::*;
#(
  parameter int unsigned DEPTH_LINES = 1024
) (
  input  logic                                     clk,
  input  logic                                     we,
  input  logic [$clog2(DEPTH_LINES)+BEAT_IDX_W-1:0] waddr,
  input  logic [BEAT_W-1:0]                        wdata,
  input  logic [$clog2(DEPTH_LINES)+BEAT_IDX_W-1:0] raddr,
  output logic [BEAT_W-1:0]                        rdata
);
  logic [BEAT_W-1:0] mem [DEPTH_LINES*BEATS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/burst_mem_responder.sv
// Memory-side responder for the 4-beat 64-bit burst interface with programmable access latency.
module burst_mem_responder
  import burst_mem_types::*;
#(
  parameter int unsigned LATENCY     = 10,
  parameter int unsigned DEPTH_LINES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_addr,
  input  logic [63:0] mem_wdata,
  output logic        mem_resp,
  output logic [63:0] mem_rdata,
  output logic        proto_err
);
  localparam int unsigned IDX_W = $clog2(DEPTH_LINES);
  localparam int unsigned LAT_W = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);

  bm_state_t              state;
  logic [IDX_W-1:0]       line_q;
  logic                   op_write_q;
  logic [BEAT_IDX_W-1:0]  beat_q;
  logic [LAT_W-1:0]       lat_cnt;
  logic                   rd_valid;

  logic [IDX_W-1:0]       req_line;
  logic                   hold;
  logic                   arr_we;
  logic [IDX_W-1:0]       rd_line;
  logic [BEAT_IDX_W-1:0]  rd_beat;
  logic [BEAT_W-1:0]      arr_q;
  logic                   unused_addr_bits;

  assign req_line         = mem_addr[OFFSET_W +: IDX_W];
  assign unused_addr_bits = ^{mem_addr[OFFSET_W-1:0], mem_addr[31:OFFSET_W+IDX_W]};
  assign hold             = op_write_q ? mem_write : mem_read;
  assign arr_we           = (state == BURST) && op_write_q && mem_write;

  // The RAM read is registered, so fetch one beat ahead: beat 0 while entering
  // BURST (from the live address when LATENCY=0), then beat+1 during BURST.
  assign rd_line = (state == IDLE)  ? req_line : line_q;
  assign rd_beat = (state == BURST) ? beat_q + 2'd1 : '0;

  burst_mem_array #(.DEPTH_LINES(DEPTH_LINES)) u_array (
    .clk   (clk),
    .we    (arr_we),
    .waddr ({line_q, beat_q}),
    .wdata (mem_wdata),
    .raddr ({rd_line, rd_beat}),
    .rdata (arr_q)
  );

  assign mem_rdata = rd_valid ? arr_q : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      line_q     <= '0;
      op_write_q <= 1'b0;
      beat_q     <= '0;
      lat_cnt    <= '0;
      rd_valid   <= 1'b0;
      mem_resp   <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_read || mem_write) begin
            line_q     <= req_line;
            op_write_q <= mem_write && !mem_read;
            beat_q     <= '0;
            lat_cnt    <= LAT_W'(LATENCY);
            if (mem_read && mem_write) proto_err <= 1'b1;
            if (LATENCY == 0) begin
              state    <= BURST;
              mem_resp <= 1'b1;
              rd_valid <= mem_read;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!hold) begin
            proto_err <= 1'b1;
            state     <= IDLE;
          end else if (lat_cnt == LAT_W'(1)) begin
            state    <= BURST;
            mem_resp <= 1'b1;
            rd_valid <= !op_write_q;
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end
        BURST: begin
          if (!hold) begin
            proto_err <= 1'b1;
            state     <= IDLE;
            mem_resp  <= 1'b0;
            rd_valid  <= 1'b0;
          end else if (beat_q == BEAT_IDX_W'(BEATS - 1)) begin
            state    <= DONE;
            mem_resp <= 1'b0;
            rd_valid <= 1'b0;
          end else begin
            beat_q <= beat_q + 2'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
